pipelined_rca_adder: RTL
========================

// Module: pipelined_rca_adder
// PURPOSE
//  Parametrised, pipelined ripple-carry add/subtract unit with a valid/ready stream interface.
//  The WIDTH-bit carry chain is cut into STAGES equal segments, and one segment resolves per clock,
//  so long operands meet timing at full throughput.
//  Sits between the visitor-count datapath and any consumer that needs wide sums or differences
//  under backpressure.
// PARAMETERS
//  WIDTH   16  operand/result width in bits; must be >= 2 and divisible by STAGES
//  STAGES  4   pipeline depth in clocks; segment width SEG = WIDTH/STAGES; STAGES=1 is legal
// PORTS
//  clk        in   1      rising-edge clock; the only clock
//  rst_n      in   1      asynchronous, active-low reset
//  in_valid   in   1      request present on a/b/cin/sub
//  in_ready   out  1      unit accepts the request this cycle
//  a          in   WIDTH  operand A (unsigned or two's complement)
//  b          in   WIDTH  operand B
//  cin        in   1      carry-in (add) / borrow-in (sub)
//  sub        in   1      0: S = A+B+cin ; 1: S = A-B-cin
//  out_valid  out  1      result present on sum/cout/ovf
//  out_ready  in   1      consumer accepts the result this cycle
//  sum        out  WIDTH  result modulo 2^WIDTH
//  cout       out  1      raw carry out of the MSB (for sub: 1 = no borrow)
//  ovf        out  1      signed overflow (carry into MSB XOR carry out of MSB)
// BEHAVIOUR
//  - Reset, asynchronous: all stage valid bits = 0, out_valid = 0, sum = 0, cout = 0, ovf = 0.
//    A reset mid-operation discards every in-flight result. No output pulses on release.
//  - Transfer: a transfer happens in a cycle where valid && ready are both high at that cycle's edge.
//    - Inputs are sampled only on an input transfer.
//    - A result stays stable while out_valid && !out_ready.
//  - Subtraction: sub=1 applies B' = ~B and carry0 = ~cin. The core always adds A + B' + carry0.
//  - Stage k (0..STAGES-1) does the following:
//    - Adds bits [k*SEG +: SEG] of A and B' with the carry registered by stage k-1.
//      Stage 0 uses carry0.
//    - Registers: its SEG result bits, the lower result bits already computed, the unused upper
//      operand bits, the carry out, and the carry into its top bit.
//  - Outputs: sum, cout and ovf come from the last stage's registers.
//    - cout is the carry out of bit WIDTH-1.
//    - ovf is c[WIDTH-1] ^ c[WIDTH].
//  - Latency: exactly STAGES cycles from the input transfer to out_valid when there are no stalls.
//    Throughput is 1 result/clk.
//  - Flow control: each stage has its own valid bit. ready_k = !valid_k || ready_{k+1}.
//    ready_STAGES = out_ready, and in_ready = ready_0 (combinational).
//    - Bubbles collapse: an empty stage loads even when downstream is stalled.
//    - With the pipe full and out_ready=0, in_ready=0 and nothing moves.
//    - With the pipe full and out_ready=1, output transfer and input transfer happen in the same cycle.
//  - Ordering: results leave in acceptance order. No drops, no duplicates.
//  - Wrap-around: sum wraps modulo 2^WIDTH. The overflow shows only in cout/ovf. Neither is sticky.
// STRUCTURE
//  - Package rca_pkg holds the SUB_OP/ADD_OP localparams and the check function
//    (WIDTH % STAGES == 0; elaboration error otherwise).
//  - Sub-module rca_stage is one SEG-bit ripple slice plus its pipeline register and valid/ready bit.
//    It is parametrised by SEG, WIDTH and its stage index.
//    pipelined_rca_adder instantiates STAGES copies with a generate loop and does the B/cin inversion.
// TESTING  (WIDTH=16, STAGES=4 unless stated)
//  1. Reset: hold rst_n=0 and drive inputs.
//     -> out_valid=0, sum=0. After release, first result appears 4 clks after its input transfer.
//  2. Add: A=16'hFFFF, B=16'h0001, cin=0, sub=0 -> sum=16'h0000, cout=1, ovf=0.
//     A=16'h7FFF, B=16'h0001 -> sum=16'h8000, cout=0, ovf=1.
//  3. Subtract: A=16'h0005, B=16'h0007, cin=0, sub=1 -> sum=16'hFFFE, cout=0, ovf=0.
//     A=16'h8000, B=16'h0001 -> sum=16'h7FFF, cout=1, ovf=1.
//  4. Streaming: 8 back-to-back random ops with out_ready=1.
//     -> 8 results on consecutive clks, in order, matching the model.
//  5. Backpressure: fill the pipe, hold out_ready=0 for 6 clks.
//     -> in_ready=0 after 4 accepts; output stable. Release -> no loss/duplication.
//  6. Reset mid-flight: assert rst_n=0 with 3 ops in flight.
//     -> out_valid drops immediately and none of the 3 ever appears. Repeat case 2 with STAGES=1
//        and WIDTH=8: latency 1.

Source files
------------

// File: rtl/rca_pkg.sv
// rtl/rca_pkg.sv - shared operation codes and parameter check for the pipelined ripple-carry adder
package rca_pkg;

    localparam logic ADD_OP = 1'b0;
    localparam logic SUB_OP = 1'b1;

    function automatic bit widths_ok(input int width, input int stages);
        return (stages >= 1) && (width >= 2) && ((width % stages) == 0);
    endfunction

endpackage

// File: rtl/rca_stage.sv
// rtl/rca_stage.sv - one SEG-bit ripple slice with its pipeline register and valid/ready bit
module rca_stage #(
    parameter int WIDTH = 16,
    parameter int SEG   = 4,
    parameter int IDX   = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic [WIDTH-1:0] s_in,
    input  logic             c_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] a_q,
    output logic [WIDTH-1:0] b_q,
    output logic [WIDTH-1:0] s_q,
    output logic             c_q,
    output logic             ctop_q
);

    localparam int LSB = IDX * SEG;

    logic [WIDTH-1:0] s_next;
    logic             c_next;
    logic             ctop_next;
    logic             c;

    // ctop_next ends up holding the carry into this slice's top bit, which
    // the last stage turns into the signed-overflow flag.
    always_comb begin
        s_next    = s_in;
        c         = c_in;
        ctop_next = c_in;
        for (int i = 0; i < SEG; i++) begin
            ctop_next         = c;
            s_next[LSB + i]   = a_in[LSB + i] ^ b_in[LSB + i] ^ c;
            c                 = (a_in[LSB + i] & b_in[LSB + i]) | (c & (a_in[LSB + i] ^ b_in[LSB + i]));
        end
        c_next = c;
    end

    assign in_ready = !out_valid || out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            s_q       <= '0;
            c_q       <= 1'b0;
            ctop_q    <= 1'b0;
        end else if (in_ready) begin
            out_valid <= in_valid;
            if (in_valid) begin
                a_q    <= a_in;
                b_q    <= b_in;
                s_q    <= s_next;
                c_q    <= c_next;
                ctop_q <= ctop_next;
            end
        end
    end

endmodule

// File: rtl/pipelined_rca_adder.sv
// rtl/pipelined_rca_adder.sv - pipelined ripple-carry add/subtract unit with valid/ready streams
module pipelined_rca_adder
    import rca_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int SEG = WIDTH / STAGES;

    if (!widths_ok(WIDTH, STAGES)) begin : g_bad_params
        $error("pipelined_rca_adder: WIDTH must be >= 2 and divisible by STAGES");
    end

    logic [WIDTH-1:0] b_eff;
    logic             c0;

    assign b_eff = (sub == SUB_OP) ? ~b : b;
    assign c0    = (sub == SUB_OP) ? ~cin : cin;

    logic [STAGES-1:0][WIDTH-1:0] a_p;
    logic [STAGES-1:0][WIDTH-1:0] b_p;
    logic [STAGES-1:0][WIDTH-1:0] s_p;
    logic [STAGES-1:0]            c_p;
    logic [STAGES-1:0]            ctop_v;
    logic [STAGES-1:0]            v_q;
    logic [STAGES-1:0]            rdy_v;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic             vin;
        logic [WIDTH-1:0] ain;
        logic [WIDTH-1:0] bin;
        logic [WIDTH-1:0] sin;
        logic             cink;
        logic             rnext;

        if (k == 0) begin : g_first
            assign vin  = in_valid;
            assign ain  = a;
            assign bin  = b_eff;
            assign sin  = '0;
            assign cink = c0;
        end else begin : g_next
            assign vin  = v_q[k-1];
            assign ain  = a_p[k-1];
            assign bin  = b_p[k-1];
            assign sin  = s_p[k-1];
            assign cink = c_p[k-1];
        end

        // Downstream ready is flattened over the valid registers so the
        // ready chain never forms a combinational path through one vector.
        if (k == STAGES - 1) begin : g_last_rdy
            assign rnext = out_ready;
        end else begin : g_mid_rdy
            assign rnext = out_ready || !(&v_q[STAGES-1:k+1]);
        end

        rca_stage #(
            .WIDTH (WIDTH),
            .SEG   (SEG),
            .IDX   (k)
        ) u_stage (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (vin),
            .in_ready  (rdy_v[k]),
            .a_in      (ain),
            .b_in      (bin),
            .s_in      (sin),
            .c_in      (cink),
            .out_valid (v_q[k]),
            .out_ready (rnext),
            .a_q       (a_p[k]),
            .b_q       (b_p[k]),
            .s_q       (s_p[k]),
            .c_q       (c_p[k]),
            .ctop_q    (ctop_v[k])
        );
    end

    assign in_ready  = rdy_v[0];
    assign out_valid = v_q[STAGES-1];
    assign sum       = s_p[STAGES-1];
    assign cout      = c_p[STAGES-1];
    assign ovf       = ctop_v[STAGES-1] ^ c_p[STAGES-1];

    logic unused_ok;
    assign unused_ok = &{1'b0, a_p[STAGES-1], b_p[STAGES-1], ctop_v, rdy_v};

endmodule
